// File: rtl/harq_combine_pipe.sv
// -----------------------------------------------------------------------------
// harq_combine_pipe
//
// HARQ soft-combine engine sitting between the descramble buffer and the HARQ
// write-combine stage. For each code block it delays the descramble LLRs so
// they line up with HARQ-memory read data that returns RD_LAT cycles after the
// strobe. It picks one of NUM_CH read channels and adds, bypasses or passes the
// old data through according to the mode latched at block start. It then
// saturates the result symmetrically, counts clipped samples and flags the end
// of the block.
//
// Ports
//   i_harq_clk              clock, rising edge
//   i_rst_n                 asynchronous active-low reset
//   i_cb_start              block start pulse; latches len / mode / channel
//   i_cb_len                number of samples in the block
//   i_combine_mode          00 combine, 01 bypass, 10 read-only, 11 = 00
//   i_ch_sel                read channel; out-of-range values select channel 0
//   i_descr_buf_data_strb   descramble sample strobe
//   i_descr_buf_data        descramble LLR
//   i_rcombine_data         read data, channel k at [k*LLR_W +: LLR_W]
//   o_combine_data_strb     output strobe
//   o_combine_data          combined, saturated LLR (holds between strobes)
//   o_sat_cnt               clipped samples in the current block (sticky max)
//   o_cb_done               one-cycle end-of-block pulse
//   o_busy                  block in RUN or DRAIN
//   o_drop                  strobe discarded outside RUN (one cycle later)
// -----------------------------------------------------------------------------
module harq_combine_pipe #(
  parameter int  LLR_W  = 8,
  parameter int  NUM_CH = 2,
  parameter int  RD_LAT = 1,
  parameter int  CNT_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_harq_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cb_start,
  input  logic [CNT_W-1:0]        i_cb_len,
  input  logic [1:0]              i_combine_mode,
  input  logic [CH_W-1:0]         i_ch_sel,
  input  logic                    i_descr_buf_data_strb,
  input  logic [LLR_W-1:0]        i_descr_buf_data,
  input  logic [NUM_CH*LLR_W-1:0] i_rcombine_data,
  output logic                    o_combine_data_strb,
  output logic [LLR_W-1:0]        o_combine_data,
  output logic [CNT_W-1:0]        o_sat_cnt,
  output logic                    o_cb_done,
  output logic                    o_busy,
  output logic                    o_drop
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // DRAIN lasts RD_LAT+1 cycles; the counter runs 0..RD_LAT.
  localparam int                    DRN_W    = $clog2(RD_LAT + 1);
  localparam logic [DRN_W-1:0]      DRN_LAST = DRN_W'(RD_LAT);
  localparam logic signed [LLR_W:0] SAT_MAX  = {2'b00, {(LLR_W-1){1'b1}}};
  localparam logic signed [LLR_W:0] SAT_MIN  = -SAT_MAX;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [DRN_W-1:0] drn_q, drn_d;

  logic             accept;   // strobe enters the delay line this cycle
  logic             flush;    // kill every sample of the previous block
  logic             drop_d;
  logic             sat_clr;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ch_d    = ch_q;
    drn_d   = drn_q;
    accept  = 1'b0;
    flush   = 1'b0;
    drop_d  = 1'b0;
    sat_clr = 1'b0;

    if (i_cb_start) begin
      // A start in any state (re)opens a block; a same-cycle strobe is its
      // first sample. An empty block goes straight to DRAIN.
      len_d   = i_cb_len;
      mode_d  = i_combine_mode;
      ch_d    = i_ch_sel;
      drn_d   = '0;
      flush   = 1'b1;
      sat_clr = 1'b1;
      if (i_cb_len == '0) begin
        cnt_d   = '0;
        drop_d  = i_descr_buf_data_strb;
        state_d = ST_DRAIN;
      end else begin
        accept  = i_descr_buf_data_strb;
        cnt_d   = i_descr_buf_data_strb ? CNT_W'(1) : '0;
        state_d = (i_descr_buf_data_strb && i_cb_len == CNT_W'(1)) ? ST_DRAIN : ST_RUN;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (i_descr_buf_data_strb) begin
            accept = 1'b1;
            cnt_d  = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = ST_DRAIN;
              drn_d   = '0;
            end
          end
        end
        ST_DRAIN: begin
          drop_d = i_descr_buf_data_strb;
          if (drn_q == DRN_LAST) begin
            state_d = ST_IDLE;
          end else begin
            drn_d = drn_q + 1'b1;
          end
        end
        default: begin
          drop_d = i_descr_buf_data_strb;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge i_harq_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      ch_q    <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ch_q    <= ch_d;
      drn_q   <= drn_d;
    end
  end

  // An abort arriving in the final DRAIN cycle suppresses the old block's done.
  assign o_cb_done = (state_q == ST_DRAIN) && (drn_q == DRN_LAST) && !i_cb_start;
  assign o_busy    = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Delay line: stage RD_LAT-1 is aligned with the read data of its sample.
  // ---------------------------------------------------------------------------
  logic [RD_LAT-1:0]            dl_strb_q;
  logic [RD_LAT-1:0][LLR_W-1:0] dl_data_q;

  // NOTE: the delay line is a short register chain, not a RAM, so it is reset
  // along with the control state and never shows stale strobes after reset.
  always_ff @(posedge i_harq_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dl_strb_q <= '0;
      dl_data_q <= '0;
    end else begin
      dl_strb_q[0] <= accept;
      dl_data_q[0] <= i_descr_buf_data;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_strb_q[i] <= dl_strb_q[i-1] & ~flush;
        dl_data_q[i] <= dl_data_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel select, combine and symmetric saturation
  // ---------------------------------------------------------------------------
  logic [LLR_W-1:0]        rd_sel;
  logic [LLR_W-1:0]        d_last;
  logic signed [LLR_W:0]   d_ext, r_ext, sum;
  logic [LLR_W-1:0]        sat_val;
  logic                    clip;
  logic                    out_strb;

  always_comb begin
    rd_sel = i_rcombine_data[0 +: LLR_W];
    for (int k = 1; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) rd_sel = i_rcombine_data[k*LLR_W +: LLR_W];
    end
  end

  assign d_last   = dl_data_q[RD_LAT-1];
  assign d_ext    = {d_last[LLR_W-1], d_last};
  assign r_ext    = {rd_sel[LLR_W-1], rd_sel};
  assign out_strb = dl_strb_q[RD_LAT-1] & ~flush;

  always_comb begin
    unique case (mode_q)
      2'b01:   sum = d_ext;
      2'b10:   sum = r_ext;
      default: sum = d_ext + r_ext;
    endcase
    clip    = 1'b0;
    sat_val = sum[LLR_W-1:0];
    // The lower bound is -MAX, so the most negative code is clipped as well.
    if (sum > SAT_MAX) begin
      clip    = 1'b1;
      sat_val = SAT_MAX[LLR_W-1:0];
    end else if (sum < SAT_MIN) begin
      clip    = 1'b1;
      sat_val = SAT_MIN[LLR_W-1:0];
    end
  end

  always_ff @(posedge i_harq_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_combine_data_strb <= 1'b0;
      o_combine_data      <= '0;
      o_sat_cnt           <= '0;
      o_drop              <= 1'b0;
    end else begin
      o_combine_data_strb <= out_strb;
      o_drop              <= drop_d;
      if (out_strb) o_combine_data <= sat_val;
      if (sat_clr) begin
        o_sat_cnt <= '0;
      end else if (out_strb && clip && (o_sat_cnt != '1)) begin
        o_sat_cnt <= o_sat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_harq_combine_pipe.sv
// -----------------------------------------------------------------------------
// tb_harq_combine_pipe
//
// Directed scenarios followed by randomized traffic against a transaction-level
// reference model: each accepted sample is queued with its output cycle, and
// the expected value is computed from the read data seen RD_LAT cycles after
// the strobe. NUM_CH is 3 so that a channel index of 3 is out of range.
// -----------------------------------------------------------------------------
module tb_harq_combine_pipe;

  localparam int LLR_W  = 8;
  localparam int NUM_CH = 3;
  localparam int RD_LAT = 2;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;
  localparam int MAXC   = 2048;
  localparam int SMAX   = 2 ** (LLR_W - 1) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    cb_start = 1'b0;
  logic [CNT_W-1:0]        cb_len = '0;
  logic [1:0]              combine_mode = '0;
  logic [CH_W-1:0]         ch_sel = '0;
  logic                    descr_strb = 1'b0;
  logic [LLR_W-1:0]        descr_data = '0;
  logic [NUM_CH*LLR_W-1:0] rcombine_data = '0;
  logic                    out_strb;
  logic [LLR_W-1:0]        out_data;
  logic [CNT_W-1:0]        sat_cnt;
  logic                    cb_done;
  logic                    busy;
  logic                    drop;

  always #5 clk = ~clk;

  harq_combine_pipe #(
    .LLR_W (LLR_W),
    .NUM_CH(NUM_CH),
    .RD_LAT(RD_LAT),
    .CNT_W (CNT_W)
  ) dut (
    .i_harq_clk           (clk),
    .i_rst_n              (rst_n),
    .i_cb_start           (cb_start),
    .i_cb_len             (cb_len),
    .i_combine_mode       (combine_mode),
    .i_ch_sel             (ch_sel),
    .i_descr_buf_data_strb(descr_strb),
    .i_descr_buf_data     (descr_data),
    .i_rcombine_data      (rcombine_data),
    .o_combine_data_strb  (out_strb),
    .o_combine_data       (out_data),
    .o_sat_cnt            (sat_cnt),
    .o_cb_done            (cb_done),
    .o_busy               (busy),
    .o_drop               (drop)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    int due;
    int d;
    int mode;
    int ch;
  } item_t;

  item_t pend[$];
  int    rd [MAXC][NUM_CH];
  int    m_len = 0, m_mode = 0, m_ch = 0, m_cnt = 0;
  int    m_done = -1, m_sat = 0, m_last = 0, m_drop = 0;
  bit    m_run = 1'b0;

  function automatic int rb();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic bit m_busy();
    return m_run || (cyc <= m_done);
  endfunction

  task automatic model_accept(input int d);
    item_t it;
    it.due  = cyc + RD_LAT + 1;
    it.d    = d;
    it.mode = m_mode;
    it.ch   = m_ch;
    pend.push_back(it);
    m_cnt++;
    if (m_cnt == m_len) begin
      m_run  = 1'b0;
      m_done = cyc + RD_LAT + 1;
    end
  endtask

  task automatic tick(input bit st, input int len, input int mode, input int ch,
                      input bit sb, input int d, input int r0, input int r1, input int r2);
    item_t it;
    int    r, v, exp_strb;
    @(negedge clk);
    cb_start     = st;
    cb_len       = CNT_W'(len);
    combine_mode = 2'(mode);
    ch_sel       = CH_W'(ch);
    descr_strb   = sb;
    descr_data   = LLR_W'(d);
    if (sb) begin
      rd[cyc+RD_LAT][0] = r0;
      rd[cyc+RD_LAT][1] = r1;
      rd[cyc+RD_LAT][2] = r2;
    end
    for (int k = 0; k < NUM_CH; k++) rcombine_data[k*LLR_W +: LLR_W] = LLR_W'(rd[cyc][k]);
    #1;

    exp_strb = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      it = pend.pop_front();
      r  = rd[cyc-1][it.ch];
      if (it.mode == 1)      v = it.d;
      else if (it.mode == 2) v = r;
      else                   v = it.d + r;
      exp_strb = 1;
      if (v > SMAX || v < -SMAX) begin
        v = (v > SMAX) ? SMAX : -SMAX;
        if (m_sat < 2 ** CNT_W - 1) m_sat++;
      end
      m_last = v;
    end
    check("strb", int'(out_strb), exp_strb);
    check("data", int'($signed(out_data)), m_last);
    check("sat_cnt", int'(sat_cnt), m_sat);
    check("cb_done", int'(cb_done), int'(m_done == cyc && !st));
    check("busy", int'(busy), int'(m_busy()));
    check("drop", int'(drop), m_drop);

    m_drop = 0;
    if (st) begin
      pend.delete();
      m_sat  = 0;
      m_len  = len;
      m_mode = mode;
      m_ch   = (ch < NUM_CH) ? ch : 0;
      m_cnt  = 0;
      m_run  = 1'b0;
      m_done = -1;
      if (len == 0) begin
        m_done = cyc + RD_LAT + 1;
        m_drop = sb;
      end else begin
        m_run = 1'b1;
        if (sb) model_accept(d);
      end
    end else if (m_run) begin
      if (sb) model_accept(d);
    end else begin
      m_drop = sb;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic strobe(input int d, input int r0, input int r1);
    tick(0, 0, 0, 0, 1, d, r0, r1, rb());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strb"}, int'(out_strb), 0);
    check({tag, "_data"}, int'(out_data), 0);
    check({tag, "_sat"}, int'(sat_cnt), 0);
    check({tag, "_done"}, int'(cb_done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_drop"}, int'(drop), 0);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    pend.delete();
    m_run  = 1'b0;
    m_done = -1;
    m_sat  = 0;
    m_last = 0;
    m_drop = 0;
    m_cnt  = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit st, sb;
    for (int c = 0; c < MAXC; c++)
      for (int k = 0; k < NUM_CH; k++) rd[c][k] = rb();

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Combine on channel 0 with two saturating samples.
    tick(1, 3, 0, 0, 1, 10, 20, 0, 0);
    strobe(100, 100, 0);
    strobe(-100, -100, 0);
    idle(5);
    check("tp1_sat", int'(sat_cnt), 2);
    check("tp1_last", int'($signed(out_data)), -127);

    // Channel 1, then out-of-range channel 3 falls back to channel 0.
    tick(1, 1, 0, 1, 1, 5, 50, -7, 0);
    idle(4);
    check("tp2_ch1", int'($signed(out_data)), -2);
    tick(1, 1, 0, 3, 1, 5, 50, -7, 0);
    idle(4);
    check("tp2_ch3", int'($signed(out_data)), 55);

    // Bypass and read-only with the most negative code.
    tick(1, 1, 1, 0, 1, -128, 90, 0, 0);
    idle(4);
    check("tp3_byp", int'($signed(out_data)), -127);
    check("tp3_sat", int'(sat_cnt), 1);
    tick(1, 1, 2, 0, 1, 40, -128, 0, 0);
    idle(4);
    check("tp3_rdo", int'($signed(out_data)), -127);

    // Len 4 with a fifth strobe, then a strobe in IDLE.
    tick(1, 4, 0, 0, 1, rb(), rb(), rb(), rb());
    for (int i = 0; i < 4; i++) strobe(rb(), rb(), rb());
    idle(5);
    strobe(7, 7, 7);
    idle(4);

    // Abort a len-8 block after 3 strobes with a start+strobe (len 2).
    tick(1, 8, 0, 0, 1, rb(), rb(), rb(), rb());
    strobe(rb(), rb(), rb());
    strobe(rb(), rb(), rb());
    tick(1, 2, 0, 1, 1, 3, 4, 5, 6);
    strobe(-9, 1, 2);
    idle(6);

    // Empty block, then reset in the middle of RUN.
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    tick(1, 8, 0, 0, 1, rb(), rb(), rb(), rb());
    strobe(rb(), rb(), rb());
    strobe(rb(), rb(), rb());
    async_reset();
    idle(3);

    // Randomized traffic including aborts, empty blocks and stray strobes.
    for (int i = 0; i < 700; i++) begin
      st = m_busy() ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 3) != 0);
      tick(st, int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), sb, rb(), rb(), rb(), rb());
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
